// File: rtl/akarin_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Owner tags and read-tracking entries.
package akarin_mem_pkg;

    localparam int MEM_AW = 12;
    localparam int MEM_DW = 32;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } mem_owner_t;

    typedef struct packed {
        logic       v;
        mem_owner_t own;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag shift pipeline: RD_LAT stages of {valid, owner}.
// Ports: clk, rst (async active-low clear), tag_in, tag_out.
import akarin_mem_pkg::*;

module rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '{v: 1'b0, own: OWN_INST};
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and load/store ports.
// Ports: i_* fetch, d_* data, m_* SRAM; clk, rst (async active-low).
import akarin_mem_pkg::*;

module mem_port_arbiter #(
    parameter int AW          = MEM_AW,
    parameter int DW          = MEM_DW,
    parameter int RD_LAT      = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);

    logic [SW-1:0] streak;
    logic          streak_max;
    logic          inst_win;
    logic          data_win;
    rd_tag_t       tag_in;
    rd_tag_t       tag_out;

    assign streak_max = (streak == SW'(MAX_DSTREAK));

    // Data has priority unless fetch has waited out a full streak.
    always_comb begin
        inst_win = rst && i_req && (!d_req || streak_max);
        data_win = rst && d_req && !inst_win;
    end

    assign i_gnt = inst_win;
    assign d_gnt = data_win;

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (inst_win) begin
            m_en   = 1'b1;
            m_be   = '1;
            m_addr = i_addr;
        end else if (data_win) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Streak only counts data grants that made a waiting fetch lose.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (inst_win || !i_req) begin
            streak <= '0;
        end else if (data_win && !streak_max) begin
            streak <= streak + SW'(1);
        end
    end

    always_comb begin
        tag_in.v   = inst_win || (data_win && !d_we);
        tag_in.own = inst_win ? OWN_INST : OWN_DATA;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign i_rvalid = tag_out.v && (tag_out.own == OWN_INST);
    assign d_rvalid = tag_out.v && (tag_out.own == OWN_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
